apb_cmd_master: RTL and testbench
=================================

// Module: apb_cmd_master
// PURPOSE
//  APB4 requester: turns single-word commands from an internal initiator (sequencer, debug bridge)
//  into APB transfers toward CSR completers such as gpio_ctrl_top. One command in flight at a time.
//  Reports the completer's read data, pslverr and a bus-hang timeout back on a response handshake.
// PARAMETERS
//  ADDR_W       16   APB address width
//  DATA_W       32   APB data width; multiple of 8
//  TIMEOUT_CYC  256  max ACCESS cycles with pready low before abort; 0 = timeout disabled
// PORTS
//  sys_clk      in   1         system clock; all logic on rising edge
//  rst          in   1         synchronous active-high reset
//  cmd_valid    in   1         command present
//  cmd_ready    out  1         command accepted when cmd_valid & cmd_ready
//  cmd_addr     in   ADDR_W    target address
//  cmd_write    in   1         1 = write, 0 = read
//  cmd_wdata    in   DATA_W    write data
//  cmd_strb     in   DATA_W/8  write byte strobes
//  rsp_valid    out  1         response present
//  rsp_ready    in   1         response consumed when rsp_valid & rsp_ready
//  rsp_rdata    out  DATA_W    read data; 0 for writes and timeouts
//  rsp_err      out  1         pslverr seen or timeout
//  rsp_timeout  out  1         transfer aborted by timeout
//  paddr        out  ADDR_W    APB address
//  psel         out  1         APB select
//  penable      out  1         APB enable
//  pwrite       out  1         APB direction
//  pwdata       out  DATA_W    APB write data
//  pstrb        out  DATA_W/8  APB strobes; forced 0 on reads
//  pprot        out  3         tied 3'b000
//  prdata       in   DATA_W    APB read data
//  pready       in   1         APB ready
//  pslverr      in   1         APB error; sampled only with pready in ACCESS
// BEHAVIOUR
//  - Reset: every output 0 (cmd_ready 0 during rst, 1 on first cycle after); state IDLE; timeout counter 0.
//  - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  - IDLE: cmd_ready=1. On cmd_valid, latch addr/write/wdata/strb (pwdata, pstrb = 0 if read); go SETUP.
//  - SETUP (exactly 1 cycle): psel=1, penable=0, paddr/pwrite/pwdata/pstrb driven from latch; go ACCESS.
//  - ACCESS: psel=1, penable=1; all APB outputs held stable. If pready: capture prdata (reads only),
//    rsp_err=pslverr, rsp_timeout=0; go RESP. Else counter++; if counter reaches TIMEOUT_CYC (!=0):
//    rsp_err=1, rsp_timeout=1, rsp_rdata=0; go RESP.
//  - RESP: psel=penable=0, paddr/pwdata/pstrb/pwrite return to 0; rsp_valid=1 with fields stable
//    until rsp_ready; then IDLE, counter cleared. cmd_ready=0 outside IDLE.
//  - Latency: accept at T -> psel at T+1, penable at T+2; zero-wait completer -> rsp_valid at T+3.
//    With rsp_ready high, back-to-back throughput one command per 4 cycles.
//  - pready/pslverr/prdata ignored outside ACCESS. A pready on the exact timeout cycle wins (normal completion).
//  - Counter width clog2(TIMEOUT_CYC+1); saturates, never wraps.
//  - rst mid-transfer: next edge all outputs 0, IDLE; the in-flight command is dropped, no response.
// TESTING
//  1. Write 0x0004=0xDEADBEEF strb 4'hF, pready=1 -> psel T+1, penable T+2, rsp_valid T+3, rsp_err=0.
//  2. Read 0x0008, 3 wait states, prdata=0x12345678 -> penable 4 cycles, paddr stable, rsp_rdata=0x12345678.
//  3. Write with pslverr=1 on pready -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
//  4. TIMEOUT_CYC=16, pready held 0 -> 16 ACCESS cycles, psel drops, rsp_err=1, rsp_timeout=1.
//  5. rsp_ready low 5 cycles after response -> rsp_valid/data stable, cmd_ready=0, psel stays 0.
//  6. rst pulse during ACCESS -> next cycle all outputs 0, no rsp_valid; next command completes normally.

Source files
------------

// File: rtl/apb_cmd_master.sv
// APB4 requester: converts single-word commands into APB transfers, one in flight,
// and returns read data / slave error / bus-hang timeout on a response handshake.
module apb_cmd_master #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    // command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic                  cmd_write,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    // response side
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // APB requester
    output logic [ADDR_W-1:0]     paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W/8-1:0]   pstrb,
    output logic [2:0]            pprot,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int unsigned STRB_W  = DATA_W / 8;
    // Counter is kept at least one bit wide so a disabled timeout still elaborates.
    localparam int unsigned CNT_W   = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]        state,       state_nxt;
    logic [CNT_W-1:0]  cnt,         cnt_nxt;
    logic              cmd_ready_nxt;
    logic              rsp_valid_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;
    logic              rsp_err_nxt;
    logic              rsp_timeout_nxt;
    logic [ADDR_W-1:0] paddr_nxt;
    logic              psel_nxt;
    logic              penable_nxt;
    logic              pwrite_nxt;
    logic [DATA_W-1:0] pwdata_nxt;
    logic [STRB_W-1:0] pstrb_nxt;

    // Protection attributes are not used by the CSR completers.
    assign pprot = 3'b000;

    // State register and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            paddr       <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cmd_ready   <= cmd_ready_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_timeout <= rsp_timeout_nxt;
            paddr       <= paddr_nxt;
            psel        <= psel_nxt;
            penable     <= penable_nxt;
            pwrite      <= pwrite_nxt;
            pwdata      <= pwdata_nxt;
            pstrb       <= pstrb_nxt;
        end
    end

    // Next-state and next-output logic; every value holds unless a transition changes it.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        cmd_ready_nxt   = cmd_ready;
        rsp_valid_nxt   = rsp_valid;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_err_nxt     = rsp_err;
        rsp_timeout_nxt = rsp_timeout;
        paddr_nxt       = paddr;
        psel_nxt        = psel;
        penable_nxt     = penable;
        pwrite_nxt      = pwrite;
        pwdata_nxt      = pwdata;
        pstrb_nxt       = pstrb;

        case (state)
            ST_IDLE: begin
                cmd_ready_nxt = 1'b1;
                // cmd_ready is qualified so the first post-reset cycle cannot accept.
                if (cmd_valid && cmd_ready) begin
                    state_nxt     = ST_SETUP;
                    cmd_ready_nxt = 1'b0;
                    cnt_nxt       = '0;
                    psel_nxt      = 1'b1;
                    penable_nxt   = 1'b0;
                    paddr_nxt     = cmd_addr;
                    pwrite_nxt    = cmd_write;
                    pwdata_nxt    = cmd_write ? cmd_wdata : '0;
                    pstrb_nxt     = cmd_write ? cmd_strb  : '0;
                end
            end

            ST_SETUP: begin
                state_nxt   = ST_ACCESS;
                penable_nxt = 1'b1;
            end

            ST_ACCESS: begin
                if (pready) begin
                    // Completion takes priority over a coincident timeout.
                    state_nxt       = ST_RESP;
                    rsp_valid_nxt   = 1'b1;
                    rsp_rdata_nxt   = pwrite ? '0 : prdata;
                    rsp_err_nxt     = pslverr;
                    rsp_timeout_nxt = 1'b0;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    paddr_nxt       = '0;
                    pwrite_nxt      = 1'b0;
                    pwdata_nxt      = '0;
                    pstrb_nxt       = '0;
                end else begin
                    if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                    if ((TIMEOUT_CYC != 0) && (cnt == CNT_W'(TO_LAST))) begin
                        state_nxt       = ST_RESP;
                        rsp_valid_nxt   = 1'b1;
                        rsp_rdata_nxt   = '0;
                        rsp_err_nxt     = 1'b1;
                        rsp_timeout_nxt = 1'b1;
                        psel_nxt        = 1'b0;
                        penable_nxt     = 1'b0;
                        paddr_nxt       = '0;
                        pwrite_nxt      = 1'b0;
                        pwdata_nxt      = '0;
                        pstrb_nxt       = '0;
                    end
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt       = ST_IDLE;
                    cnt_nxt         = '0;
                    cmd_ready_nxt   = 1'b1;
                    rsp_valid_nxt   = 1'b0;
                    rsp_rdata_nxt   = '0;
                    rsp_err_nxt     = 1'b0;
                    rsp_timeout_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: APB timing, wait states, slave error,
// timeout, response back-pressure, throughput and mid-transfer reset.
module tb_apb_cmd_master;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned TO_CYC = 16;

    logic              sys_clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_write;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [2:0]        pprot;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    int n_checks = 0;
    int n_pass   = 0;
    int pen;
    int n;

    always #5 sys_clk = ~sys_clk;

    apb_cmd_master #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_write   (cmd_write),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pprot       (pprot),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [127:0] all_outs();
        return {cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
                paddr, psel, penable, pwrite, pwdata, pstrb, pprot};
    endfunction

    // Present one command for one cycle; returns in the SETUP cycle.
    task automatic issue(input logic [ADDR_W-1:0] a, input logic w,
                         input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
        check("issue_cmd_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_write = w;
        cmd_wdata = d;
        cmd_strb  = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid, counting cycles with penable high.
    task automatic wait_rsp(input int max_cyc, output int pen_cyc);
        pen_cyc = 0;
        for (int i = 0; i < max_cyc && !rsp_valid; i++) begin
            if (penable) pen_cyc++;
            tick();
        end
        check("rsp_wait", rsp_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_write = 1'b0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // Reset state
        repeat (3) tick();
        check("reset_outs", all_outs(), 128'h0);
        rst = 1'b0;
        tick();
        tick();
        check("cmd_ready_after_rst", cmd_ready, 1'b1);

        // 1: zero-wait write
        pready = 1'b1;
        prdata = 32'h0BAD0BAD;
        issue(16'h0004, 1'b1, 32'hDEADBEEF, 4'hF);
        check("t1_setup", {psel, penable, pwrite, paddr, pwdata, pstrb, cmd_ready},
              {1'b1, 1'b0, 1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 1'b0});
        tick();
        check("t1_access", {psel, penable, paddr, pwdata, rsp_valid},
              {1'b1, 1'b1, 16'h0004, 32'hDEADBEEF, 1'b0});
        tick();
        check("t1_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b100, 32'h0});
        check("t1_bus_idle", {psel, penable, pwrite, paddr, pwdata, pstrb}, 128'h0);
        rsp_ready = 1'b1;
        tick();
        check("t1_done", {rsp_valid, cmd_ready}, 2'b01);
        rsp_ready = 1'b0;

        // 2: read with 3 wait states
        pready = 1'b0;
        prdata = 32'hFFFF0000;
        issue(16'h0008, 1'b0, 32'hFFFFFFFF, 4'hF);
        check("t2_setup", {psel, penable, pwrite, paddr, pwdata, pstrb},
              {1'b1, 1'b0, 1'b0, 16'h0008, 32'h0, 4'h0});
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_access%0d", i), {psel, penable, paddr, rsp_valid},
                  {1'b1, 1'b1, 16'h0008, 1'b0});
            if (i == 3) begin
                pready = 1'b1;
                prdata = 32'h12345678;
            end
            tick();
        end
        pready = 1'b0;
        prdata = 32'h0;
        check("t2_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b100, 32'h12345678});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 3: write answered with pslverr
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hFFFFFFFF;
        issue(16'h0010, 1'b1, 32'hA5A5A5A5, 4'h3);
        check("t3_setup", {pwrite, paddr, pwdata, pstrb}, {1'b1, 16'h0010, 32'hA5A5A5A5, 4'h3});
        wait_rsp(10, pen);
        check("t3_pen_cycles", pen, 1);
        check("t3_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b110, 32'h0});
        pslverr   = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 4: timeout with pready held low
        pready = 1'b0;
        prdata = 32'h55AA55AA;
        issue(16'h0020, 1'b0, 32'h0, 4'h0);
        wait_rsp(40, pen);
        check("t4_pen_cycles", pen, TO_CYC);
        check("t4_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b111, 32'h0});
        check("t4_bus_idle", {psel, penable, paddr}, 128'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 5: response back-pressure
        pready = 1'b1;
        prdata = 32'hCAFEF00D;
        issue(16'h0030, 1'b0, 32'h0, 4'h0);
        wait_rsp(10, pen);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t5_stall%0d", i),
                  {rsp_valid, rsp_err, rsp_timeout, rsp_rdata, cmd_ready, psel, penable},
                  {3'b100, 32'hCAFEF00D, 3'b000});
            prdata = 32'h0;
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("t5_release", {rsp_valid, cmd_ready}, 2'b01);

        // Back-to-back throughput: one command per 4 cycles
        pready    = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr  = 16'h0040;
        cmd_write = 1'b1;
        cmd_wdata = 32'h00000001;
        cmd_strb  = 4'hF;
        wait_rsp(10, pen);
        tick();
        n = 1;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        check("b2b_period", n, 4);
        cmd_valid = 1'b0;
        tick();
        check("b2b_idle", {cmd_ready, rsp_valid, psel}, 3'b100);

        // 6: reset during ACCESS
        pready = 1'b0;
        issue(16'h0050, 1'b1, 32'h11223344, 4'hF);
        tick();
        tick();
        check("t6_in_access", {psel, penable, paddr}, {2'b11, 16'h0050});
        rst = 1'b1;
        tick();
        check("t6_rst_outs", all_outs(), 128'h0);
        rst    = 1'b0;
        pready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t6_no_rsp%0d", i), {rsp_valid, psel}, 2'b00);
            tick();
        end
        check("t6_ready_again", cmd_ready, 1'b1);
        issue(16'h0060, 1'b1, 32'h00000099, 4'h1);
        check("t6_setup", {psel, paddr, pwdata, pstrb}, {1'b1, 16'h0060, 32'h99, 4'h1});
        wait_rsp(10, pen);
        check("t6_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b100);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
